// File: rtl/r_type_seq_ctrl.sv
// r_type_seq_ctrl: multi-cycle sequencer for RV32 R-type instructions.
// It fetches each instruction, decodes it to an ALU select, retires it, and traps on an illegal word or a fetch timeout.
module r_type_seq_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        trap_clr,
    output logic        imem_req,
    output logic [31:0] instrCode,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        pcEn,
    output logic        busy,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] retire_cnt
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, TRAP} state_t;
    state_t state, nxt;
    logic [7:0] wcnt;
    logic [3:0] dec_alu;
    logic map_ok, legal;
    always_comb begin
        dec_alu = 4'd0;
        map_ok  = 1'b1;
        case ({instrCode[30], instrCode[14:12]})
            4'b0000: dec_alu = 4'd0;
            4'b1000: dec_alu = 4'd1;
            4'b0111: dec_alu = 4'd2;
            4'b0110: dec_alu = 4'd3;
            4'b0001: dec_alu = 4'd4;
            4'b0101: dec_alu = 4'd5;
            4'b1101: dec_alu = 4'd6;
            4'b0010: dec_alu = 4'd7;
            4'b0011: dec_alu = 4'd8;
            4'b0100: dec_alu = 4'd9;
            default: map_ok = 1'b0;
        endcase
    end
    assign legal = instrCode[6:0] == 7'b0110011 && !instrCode[31] && instrCode[29:25] == 5'd0 && map_ok;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = run ? FETCH : IDLE;
            FETCH:   nxt = imem_ack ? DECODE : (wcnt == 8'(TIMEOUT - 1) ? TRAP : FETCH);
            DECODE:  nxt = legal ? EXEC : TRAP;
            EXEC:    nxt = WB;
            WB:      nxt = run ? FETCH : IDLE;
            TRAP:    nxt = trap_clr ? IDLE : TRAP;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        imem_req  = state == FETCH;
        regFileWe = state == WB;
        pcEn      = state == WB;
        trap      = state == TRAP;
        busy      = state != IDLE && state != TRAP;
    end
    // The wait counter idles at zero outside FETCH, so every FETCH entry starts a fresh count.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wcnt       <= '0;
            instrCode  <= '0;
            aluControl <= '0;
            retire_cnt <= '0;
            trap_cause <= '0;
        end else begin
            wcnt <= state == FETCH ? wcnt + 8'd1 : 8'd0;
            if (state == FETCH && imem_ack) instrCode <= imem_rdata;
            if (state == DECODE && legal) aluControl <= dec_alu;
            if (state == WB) retire_cnt <= retire_cnt + 32'd1;
            if (state != TRAP && nxt == TRAP) trap_cause <= state == DECODE ? 2'd1 : 2'd2;
            else if (state == TRAP && trap_clr) trap_cause <= 2'd0;
        end
endmodule

// File: tb/tb_r_type_seq_ctrl.sv
// tb_r_type_seq_ctrl: directed checks of the R-type sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_r_type_seq_ctrl;
    logic        clk = 0;
    logic        reset_n, run, imem_ack, trap_clr;
    logic [31:0] imem_rdata;
    logic        imem_req, regFileWe, pcEn, busy, trap;
    logic [31:0] instrCode, retire_cnt;
    logic [3:0]  aluControl;
    logic [1:0]  trap_cause;
    int checks = 0, errors = 0;

    r_type_seq_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .trap_clr(trap_clr), .imem_req(imem_req),
        .instrCode(instrCode), .regFileWe(regFileWe), .aluControl(aluControl),
        .pcEn(pcEn), .busy(busy), .trap(trap), .trap_cause(trap_cause),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 0; run = 0; imem_ack = 0; trap_clr = 0; imem_rdata = '0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
    endtask

    // Called at a negedge while in FETCH; returns at the negedge after WB.
    task automatic exec_instr(input logic [31:0] w, input logic [3:0] alu, input string tag);
        check({tag, " fetch req"}, imem_req, 1);
        imem_ack = 1; imem_rdata = w;
        @(negedge clk);
        imem_ack = 0; imem_rdata = 32'hDEAD_BEEF;
        check({tag, " ir"}, instrCode, w);
        check({tag, " decode we"}, regFileWe, 0);
        @(negedge clk);
        check({tag, " exec alu"}, aluControl, alu);
        check({tag, " exec we"}, {regFileWe, pcEn}, 0);
        @(negedge clk);
        check({tag, " wb we/pc"}, {regFileWe, pcEn}, 2'b11);
        check({tag, " wb alu"}, aluControl, alu);
        @(negedge clk);
        check({tag, " after wb we"}, regFileWe, 0);
    endtask

    initial begin
        reset_n = 0; run = 0; imem_ack = 0; trap_clr = 0; imem_rdata = '0;
        #2;
        check("reset outs", {imem_req, regFileWe, pcEn, busy, trap, trap_cause}, 0);
        check("reset cnt", retire_cnt, 0);
        check("reset ir", instrCode, 0);
        @(negedge clk);
        reset_n = 1;
        imem_ack = 1; imem_rdata = 32'h002081B3;
        @(negedge clk);
        check("idle ignores ack", {busy, imem_req}, 0);
        imem_ack = 0;

        // single add
        run = 1;
        @(negedge clk);
        exec_instr(32'h002081B3, 4'd0, "add");
        check("add retire", retire_cnt, 1);
        check("add refetch", imem_req, 1);

        // back-to-back sub, sra
        do_reset();
        run = 1;
        @(negedge clk);
        exec_instr(32'h402081B3, 4'd1, "sub");
        exec_instr(32'h4020D1B3, 4'd6, "sra");
        check("subsra retire", retire_cnt, 2);
        exec_instr(32'h0020E1B3, 4'd3, "or");
        exec_instr(32'h0020C1B3, 4'd9, "xor");
        check("4 retire", retire_cnt, 4);

        // illegal addi
        do_reset();
        run = 1;
        @(negedge clk);
        imem_ack = 1; imem_rdata = 32'h00208193;
        @(negedge clk);
        imem_ack = 0;
        check("addi decode we", regFileWe, 0);
        @(negedge clk);
        check("addi trap", {trap, trap_cause}, 3'b101);
        check("addi trap quiet", {regFileWe, pcEn, imem_req, busy}, 0);
        check("addi retire", retire_cnt, 0);
        @(negedge clk);
        check("trap ignores run", {trap, imem_req}, 2'b10);
        run = 0; trap_clr = 1;
        @(negedge clk);
        trap_clr = 0;
        check("trap clr", {trap, trap_cause, busy}, 0);

        // illegal funct combo, aluControl must keep the last legal value
        run = 1;
        @(negedge clk);
        exec_instr(32'h4020D1B3, 4'd6, "sra2");
        imem_ack = 1; imem_rdata = 32'h4020C1B3;
        @(negedge clk);
        imem_ack = 0;
        @(negedge clk);
        check("bad funct trap", {trap, trap_cause}, 3'b101);
        check("bad funct alu hold", aluControl, 6);
        check("bad funct retire", retire_cnt, 1);

        // fetch timeout
        do_reset();
        run = 1;
        begin
            int n = 0;
            for (int i = 0; i < 40 && !trap; i++) begin
                @(negedge clk);
                if (imem_req) n++;
            end
            check("timeout req cycles", n, 16);
            check("timeout trap", {trap, trap_cause}, 3'b110);
        end

        // reset during WB
        do_reset();
        run = 1;
        @(negedge clk);
        exec_instr(32'h002081B3, 4'd0, "pre");
        imem_ack = 1; imem_rdata = 32'h402081B3;
        @(negedge clk);
        imem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        check("wb before reset", {regFileWe, retire_cnt[7:0]}, 9'h101);
        reset_n = 0;
        #1;
        check("async reset we/pc", {regFileWe, pcEn, busy}, 0);
        check("async reset cnt", retire_cnt, 0);
        check("async reset alu", aluControl, 0);
        run = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // run dropped in EXEC
        run = 1;
        @(negedge clk);
        imem_ack = 1; imem_rdata = 32'h002081B3;
        @(negedge clk);
        imem_ack = 0;
        @(negedge clk);
        run = 0;
        @(negedge clk);
        check("drop wb we", regFileWe, 1);
        @(negedge clk);
        check("drop retire", retire_cnt, 1);
        check("drop idle", {busy, imem_req}, 0);
        @(negedge clk);
        @(negedge clk);
        check("drop stays idle", {busy, imem_req}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/r_type_seq_ctrl.md
R_TYPE_SEQ_CTRL -- requirements
Module: r_type_seq_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: TIMEOUT, 16, max FETCH cycles to wait for imem_ack before trapping (range 2..255).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: run  input  1  level; 1 = keep executing instructions.
REQ-006 Port: imem_ack  input  1  instruction memory data valid.
REQ-007 Port: imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 Port: trap_clr  input  1  clears TRAP state.
REQ-009 Port: imem_req  output  1  instruction fetch request.
REQ-010 Port: instrCode  output  32  latched instruction register (IR) to datapath.
REQ-011 Port: regFileWe  output  1  register file write enable.
REQ-012 Port: aluControl  output  4  ALU operation select.
REQ-013 Port: pcEn  output  1  PC advance strobe.
REQ-014 Port: busy  output  1  state is not IDLE and not TRAP.
REQ-015 Port: trap  output  1  state is TRAP.
REQ-016 Port: trap_cause  output  2  0 none, 1 illegal instruction, 2 fetch timeout.
REQ-017 Port: retire_cnt  output  32  count of completed instructions.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, EXEC, WB, TRAP; one-hot or binary encoding is an implementation choice.
REQ-019 IDLE: go to FETCH when run=1; imem_ack ignored.
REQ-020 FETCH: imem_req=1 every cycle; on imem_ack=1 load IR from imem_rdata that edge and go DECODE.
REQ-021 FETCH wait counter SHALL reset on FETCH entry; if imem_ack is still 0 in the TIMEOUT-th FETCH cycle, go TRAP with trap_cause=2.
REQ-022 DECODE: instruction legal iff opcode[6:0]=0110011, bit31=0, bits[29:25]=0, and {bit30,funct3} is in REQ-023; legal -> EXEC with aluControl registered, illegal -> TRAP with trap_cause=1.
REQ-023 Map {bit30,funct3}->aluControl: 0000 add 0; 1000 sub 1; 0111 and 2; 0110 or 3; 0001 sll 4; 0101 srl 5; 1101 sra 6; 0010 slt 7; 0011 sltu 8; 0100 xor 9; all other values illegal.
REQ-024 EXEC: one cycle, then WB.
REQ-025 WB: one cycle; regFileWe=1, pcEn=1, retire_cnt increments by 1 (wraps 0xFFFFFFFF->0); then FETCH if run=1, else IDLE.
REQ-026 regFileWe and pcEn SHALL be 1 only in WB; imem_req SHALL be 1 only in FETCH.
REQ-027 aluControl SHALL hold its DECODE value through EXEC and WB until the next legal DECODE.
REQ-028 Deasserting run mid-instruction SHALL NOT abort it; the instruction completes WB, then the block goes IDLE.
REQ-029 Latency with imem_ack in the first FETCH cycle SHALL be 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
REQ-030 TRAP: trap=1; no write, fetch or PC strobe; trap_clr=1 -> IDLE and trap_cause=0; run is ignored.
REQ-031 An illegal instruction SHALL NOT increment retire_cnt or assert regFileWe.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE and clear all outputs to 0, including the wait counter, even mid-instruction.

Verification
REQ-033 Reset, run=1, ack with 0x002081B3 (add) in the first FETCH cycle -> aluControl=0; regFileWe=pcEn=1 in cycle 4 only; retire_cnt=1.
REQ-034 Back-to-back 0x402081B3 (sub) then 0x4020D1B3 (sra) -> aluControl 1 then 6; regFileWe pulses 4 cycles apart; retire_cnt=2.
REQ-035 Ack with 0x00208193 (addi) -> TRAP, trap_cause=1, regFileWe never 1, retire_cnt unchanged; trap_clr=1 -> IDLE, trap_cause=0.
REQ-036 run=1, imem_ack held 0 -> imem_req high for 16 cycles, then trap=1 with trap_cause=2.
REQ-037 reset_n=0 during WB -> regFileWe, pcEn and retire_cnt read 0 immediately; state is IDLE.
REQ-038 run dropped during EXEC -> WB completes (retire_cnt+1), then IDLE, and imem_req stays 0.
